// File: rtl/truth_table_sweeper.sv
// Truth-table sweeper: drives every input row of an N-input gate, samples its output and
// packs/compares a 2^N-bit signature. Optional macro SWEEP_SYNC_EN adds a 2-flop input synchronizer.
module truth_table_sweeper #(
  parameter int N_IN          = 4,
  parameter int SETTLE_CYCLES = 4,
  localparam int W            = 2 ** N_IN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  input  logic [W-1:0]    expected,
  output logic [N_IN-1:0] tt_in,
  input  logic            tt_out,
  output logic            busy,
  output logic            done,
  output logic [W-1:0]    signature,
  output logic [W-1:0]    mismatch,
  output logic            pass
);

  localparam int ROW_W = N_IN + 1;
  localparam int CNT_W = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  state_t           state_reg, state_next;
  logic [ROW_W-1:0] row_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [W-1:0]     exp_reg;
  logic [W-1:0]     row_sel;
  logic             sample_bit;
  logic             last_row;
  logic             settle_end;

`ifdef SWEEP_SYNC_EN
  logic sync1_reg, sync2_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
    end else begin
      sync1_reg <= tt_out;
      sync2_reg <= sync1_reg;
    end
  end

  assign sample_bit = sync2_reg;
`else
  assign sample_bit = tt_out;
`endif

  // One-hot bit position for the current row: row k lands in signature[W-1-k].
  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_row_sel
      assign row_sel[gi] = (row_reg == ROW_W'(W - 1 - gi));
    end
  endgenerate

  assign last_row   = (row_reg == ROW_W'(W - 1));
  assign settle_end = (cnt_reg == CNT_W'(SETTLE_CYCLES - 1));

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start && !abort) state_next = SETTLE;
      SETTLE:  if (abort) state_next = IDLE;
               else if (settle_end) state_next = SAMPLE;
      SAMPLE:  if (abort) state_next = IDLE;
               else if (last_row) state_next = DONE;
               else state_next = SETTLE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_reg   <= '0;
      cnt_reg   <= '0;
      exp_reg   <= '0;
      tt_in     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      signature <= '0;
      mismatch  <= '0;
      pass      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state_reg != IDLE && abort) begin
        // Abort keeps the rows already captured but invalidates the verdict.
        tt_in    <= '0;
        busy     <= 1'b0;
        mismatch <= '0;
        pass     <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: begin
            tt_in <= '0;
            if (start && !abort) begin
              exp_reg   <= expected;
              signature <= '0;
              mismatch  <= '0;
              pass      <= 1'b0;
              row_reg   <= '0;
              cnt_reg   <= '0;
              busy      <= 1'b1;
            end
          end
          SETTLE: cnt_reg <= cnt_reg + CNT_W'(1);
          SAMPLE: begin
            signature <= (signature & ~row_sel) | (row_sel & {W{sample_bit}});
            if (!last_row) begin
              row_reg <= row_reg + ROW_W'(1);
              cnt_reg <= '0;
              tt_in   <= tt_in + N_IN'(1);
            end
          end
          DONE: begin
            done     <= 1'b1;
            mismatch <= signature ^ exp_reg;
            pass     <= (signature == exp_reg);
            busy     <= 1'b0;
            tt_in    <= '0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench: a 0x0038 gate model (or a tied-high output) is swept by the sequencer.
module tb_truth_table_sweeper;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] expected = '0;
  logic [3:0]  tt_in;
  logic        tt_out;
  logic        busy, done, pass;
  logic [15:0] signature, mismatch;

  logic        start2 = 1'b0;
  logic        abort2 = 1'b0;
  logic [15:0] expected2 = '0;
  logic [3:0]  tt_in2;
  logic        one_bit;
  logic        busy2, done2, pass2;
  logic [15:0] signature2, mismatch2;

  logic [15:0] gate_tt = 16'h0038;
  logic        force_one = 1'b0;

  int checks = 0;
  int failures = 0;
  int at;
  int n;

  assign tt_out  = force_one | gate_tt[4'd15 - tt_in];
  assign one_bit = 1'b1;

  always #5 clk = ~clk;

  truth_table_sweeper #(.N_IN(4), .SETTLE_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .expected(expected),
    .tt_in(tt_in), .tt_out(tt_out), .busy(busy), .done(done),
    .signature(signature), .mismatch(mismatch), .pass(pass)
  );

  truth_table_sweeper #(.N_IN(4), .SETTLE_CYCLES(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2), .expected(expected2),
    .tt_in(tt_in2), .tt_out(one_bit), .busy(busy2), .done(done2),
    .signature(signature2), .mismatch(mismatch2), .pass(pass2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
    checks++;
    assert (obs === req) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
    end
  endtask

  // Start is sampled on the next rising edge, which becomes cycle 0.
  task automatic pulse_start(input logic [15:0] e);
    @(negedge clk);
    expected = e;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int from, output int when);
    when = -1;
    for (int i = from + 1; i <= from + 200; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        when = i;
        break;
      end
    end
  endtask

  task automatic count_done(input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (done || busy) cnt++;
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_tt_in", 32'(tt_in), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_signature", 32'(signature), 32'h0);
    check("rst_mismatch", 32'(mismatch), 32'h0);
    check("rst_pass", 32'(pass), 32'h0);
    @(negedge clk) rst_n = 1'b1;

    // 1: matching expected value
    pulse_start(16'h0038);
    check("t1_busy_after_start", 32'(busy), 32'h1);
    check("t1_tt_in_row0", 32'(tt_in), 32'h0);
    wait_done(0, at);
    $display("t1 done_cycle=%0d signature=%h pass=%0d", at, signature, pass);
    check("t1_done_cycle", 32'(at), 32'd81);
    check("t1_signature", 32'(signature), 32'h0038);
    check("t1_pass", 32'(pass), 32'h1);
    check("t1_mismatch", 32'(mismatch), 32'h0);
    check("t1_busy_at_done", 32'(busy), 32'h0);
    @(posedge clk);
    #1;
    check("t1_done_one_cycle", 32'(done), 32'h0);

    // 2: expected differs in the last row
    pulse_start(16'h0039);
    repeat (50) @(posedge clk);
    #1;
    check("t2_tt_in_row10", 32'(tt_in), 32'd10);
    wait_done(50, at);
    $display("t2 done_cycle=%0d mismatch=%h pass=%0d", at, mismatch, pass);
    check("t2_done_cycle", 32'(at), 32'd81);
    check("t2_pass", 32'(pass), 32'h0);
    check("t2_mismatch", 32'(mismatch), 32'h0001);
    check("t2_signature", 32'(signature), 32'h0038);

    // 3: abort sampled at cycle 30 (row 5 in SAMPLE); rows 0..4 captured as ones
    force_one = 1'b1;
    pulse_start(16'h0038);
    repeat (29) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    $display("t3 abort busy=%0d tt_in=%0d signature=%h", busy, tt_in, signature);
    check("t3_abort_busy", 32'(busy), 32'h0);
    check("t3_abort_tt_in", 32'(tt_in), 32'h0);
    check("t3_abort_pass", 32'(pass), 32'h0);
    check("t3_abort_mismatch", 32'(mismatch), 32'h0);
    check("t3_abort_signature", 32'(signature), 32'hF800);
    count_done(100, n);
    check("t3_no_done_after_abort", 32'(n), 32'h0);
    force_one = 1'b0;
    pulse_start(16'h0038);
    wait_done(0, at);
    $display("t3 restart done_cycle=%0d pass=%0d", at, pass);
    check("t3_restart_done_cycle", 32'(at), 32'd81);
    check("t3_restart_pass", 32'(pass), 32'h1);

    // 4: start re-pulsed at cycle 10 is ignored
    pulse_start(16'h0038);
    repeat (9) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check("t4_busy_cycle10", 32'(busy), 32'h1);
    wait_done(10, at);
    $display("t4 done_cycle=%0d", at);
    check("t4_done_cycle", 32'(at), 32'd81);
    count_done(100, n);
    check("t4_single_done", 32'(n), 32'h0);

    // 5: asynchronous reset at cycle 40
    force_one = 1'b1;
    pulse_start(16'hFFFF);
    repeat (40) @(posedge clk);
    #1;
    check("t5_partial_signature", 32'(signature), 32'hFF00);
    rst_n = 1'b0;
    #1;
    $display("t5 reset busy=%0d tt_in=%0d signature=%h", busy, tt_in, signature);
    check("t5_rst_busy", 32'(busy), 32'h0);
    check("t5_rst_tt_in", 32'(tt_in), 32'h0);
    check("t5_rst_signature", 32'(signature), 32'h0);
    check("t5_rst_done", 32'(done), 32'h0);
    check("t5_rst_mismatch_pass", 32'({mismatch, 15'h0, pass}), 32'h0);
    @(negedge clk) rst_n = 1'b1;
    count_done(30, n);
    check("t5_idle_after_release", 32'(n), 32'h0);

    // start and abort together in IDLE: abort wins
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    check("idle_start_abort_busy", 32'(busy), 32'h0);

    // 6: tied-high output, both settle configurations
    pulse_start(16'hFFFF);
    wait_done(0, at);
    $display("t6 done_cycle=%0d signature=%h pass=%0d", at, signature, pass);
    check("t6_done_cycle", 32'(at), 32'd81);
    check("t6_signature", 32'(signature), 32'hFFFF);
    check("t6_pass", 32'(pass), 32'h1);
    force_one = 1'b0;

    @(negedge clk);
    expected2 = 16'hFFFF;
    start2 = 1'b1;
    @(posedge clk);
    #1 start2 = 1'b0;
    at = -1;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk);
      #1;
      if (done2) begin
        at = i;
        break;
      end
    end
    $display("t6b done_cycle=%0d signature=%h pass=%0d", at, signature2, pass2);
    check("t6b_done_cycle", 32'(at), 32'd49);
    check("t6b_signature", 32'(signature2), 32'hFFFF);
    check("t6b_pass", 32'(pass2), 32'h1);
    check("t6b_mismatch", 32'(mismatch2), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
